// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C target: filtered START/STOP detect, 7-bit address match, RX/TX bytes with ACK/NACK.
// Define I2C_SLAVE_GEN_CALL_EN to also accept the general-call write address 8'h00.
module i2c_slave_byte_ctrl #(
  parameter int FILT = 3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oen,
  input  logic [6:0] My_addr,
  input  logic       Ack_en,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  input  logic [7:0] Tx_data,
  output logic       Tx_load,
  output logic       Tx_nack,
  output logic       Busy,
  output logic       Rw,
  output logic       Stop_det
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_WAIT
  } state_t;

  // Line index 0 = SCL, 1 = SDA
  logic [1:0] s1_q, s2_q, f_q, fp_q;
  logic [2:0] fcnt_q [2];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      f_q       <= 2'b11;
      fp_q      <= 2'b11;
      fcnt_q[0] <= 3'd0;
      fcnt_q[1] <= 3'd0;
    end else begin
      s1_q <= {Sda_i, Scl_i};
      s2_q <= s1_q;
      fp_q <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          fcnt_q[i] <= 3'd0;
        end else if (fcnt_q[i] == 3'(FILT - 1)) begin
          f_q[i]    <= s2_q[i];
          fcnt_q[i] <= 3'd0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 3'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = f_q[0] & ~fp_q[0];
  assign scl_fall  = ~f_q[0] & fp_q[0];
  assign start_det = f_q[0] & fp_q[0] & fp_q[1] & ~f_q[1];
  assign stop_det  = f_q[0] & fp_q[0] & ~fp_q[1] & f_q[1];

  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d, mack_q, mack_d;
  logic       sda_oen_q, sda_oen_d, rw_q, rw_d, busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d, tx_load_q, tx_load_d;
  logic       tx_nack_q, tx_nack_d, stop_q, stop_d;
  logic [7:0] byte_in;
  logic       addr_hit;

  assign byte_in = {shift_q[6:0], f_q[1]};
`ifdef I2C_SLAVE_GEN_CALL_EN
  assign addr_hit = (byte_in[7:1] == My_addr) || (byte_in == 8'h00);
`else
  assign addr_hit = (byte_in[7:1] == My_addr);
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      mack_q     <= 1'b0;
      sda_oen_q  <= 1'b1;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      tx_nack_q  <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      mack_q     <= mack_d;
      sda_oen_q  <= sda_oen_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      tx_nack_q  <= tx_nack_d;
      stop_q     <= stop_d;
    end
  end

  // done_q marks "8th rise seen" (or ACK bit sampled) so the following fall acts on it
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    done_d     = done_q;
    mack_d     = mack_q;
    sda_oen_d  = sda_oen_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    tx_nack_d  = 1'b0;
    stop_d     = 1'b0;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_d     = 3'd0;
      done_d    = 1'b0;
      sda_oen_d = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_d     = 3'd0;
      done_d    = 1'b0;
      sda_oen_d = 1'b1;
      busy_d    = 1'b0;
      stop_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (addr_hit) begin
                rw_d   = byte_in[0];
                done_d = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end else if (scl_fall && done_q) begin
            sda_oen_d = 1'b0;
            done_d    = 1'b0;
            state_d   = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oen_d = 1'b1;
            state_d   = ST_RX;
            if (rw_q) begin
              shift_d   = Tx_data;
              tx_load_d = 1'b1;
              sda_oen_d = Tx_data[7];
              bit_d     = 3'd0;
              state_d   = ST_TX;
            end
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            shift_d = byte_in;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            sda_oen_d = ~Ack_en;
            done_d    = 1'b0;
            state_d   = ST_RX_ACK;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oen_d = 1'b1;
            state_d   = ST_RX;
          end
        end
        // Bit 7 is already on the line at load; seven falls shift out 6..0, the eighth releases
        ST_TX: begin
          if (scl_fall) begin
            if (bit_q == 3'd7) begin
              sda_oen_d = 1'b1;
              bit_d     = 3'd0;
              state_d   = ST_TX_ACK;
            end else begin
              sda_oen_d = shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_d     = bit_q + 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            mack_d = ~f_q[1];
            done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (mack_q) begin
              shift_d   = Tx_data;
              tx_load_d = 1'b1;
              sda_oen_d = Tx_data[7];
              bit_d     = 3'd0;
              state_d   = ST_TX;
            end else begin
              tx_nack_d = 1'b1;
              state_d   = ST_WAIT;
            end
          end
        end
        ST_WAIT: sda_oen_d = 1'b1;
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign Sda_oen  = sda_oen_q;
  assign Rx_data  = rx_data_q;
  assign Rx_valid = rx_valid_q;
  assign Tx_load  = tx_load_q;
  assign Tx_nack  = tx_nack_q;
  assign Busy     = busy_q;
  assign Rw       = rw_q;
  assign Stop_det = stop_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl: a bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_slave_byte_ctrl;

  localparam int FILT = 3;
  localparam int H    = 10;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       scl_m, sda_m;
  logic       Sda_oen;
  logic [6:0] My_addr;
  logic       Ack_en;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic [7:0] Tx_data;
  logic       Tx_load, Tx_nack, Busy, Rw, Stop_det;
  logic       sda_bus;

  int errors = 0;
  int checks = 0;
  int n_rxv = 0, n_ld = 0, n_nack = 0, n_stop = 0, n_busy_rise = 0;
  int ld_snap;
  logic busy_prev = 1'b0;

  assign sda_bus = sda_m & Sda_oen;

  always #5 Clk = ~Clk;

  i2c_slave_byte_ctrl #(.FILT(FILT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Scl_i(scl_m), .Sda_i(sda_bus), .Sda_oen(Sda_oen),
    .My_addr(My_addr), .Ack_en(Ack_en), .Rx_data(Rx_data), .Rx_valid(Rx_valid),
    .Tx_data(Tx_data), .Tx_load(Tx_load), .Tx_nack(Tx_nack), .Busy(Busy), .Rw(Rw),
    .Stop_det(Stop_det)
  );

  always @(negedge Clk) begin
    if (Rx_valid) n_rxv = n_rxv + 1;
    if (Tx_load)  n_ld = n_ld + 1;
    if (Tx_nack)  n_nack = n_nack + 1;
    if (Stop_det) n_stop = n_stop + 1;
    if (Busy && !busy_prev) n_busy_rise = n_busy_rise + 1;
    busy_prev = Busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic i2c_start;
    scl_m = 1'b0; tick(H);
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(2*H);
    sda_m = 1'b0; tick(2*H);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic i2c_stop;
    scl_m = 1'b0; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b1; tick(2*H);
    sda_m = 1'b1; tick(4*H);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(H);
      scl_m = 1'b1; tick(2*H);
      scl_m = 1'b0; tick(H);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H);
    ack = ~sda_bus;
    ld_snap = n_ld;
    tick(H);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(H);
      scl_m = 1'b1; tick(H);
      b[i] = sda_bus;
      tick(H);
      scl_m = 1'b0; tick(H);
    end
    sda_m = ~ack; tick(H);
    scl_m = 1'b1; tick(2*H);
    scl_m = 1'b0; tick(H);
    sda_m = 1'b1;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    My_addr = 7'h2A; Ack_en = 1'b1; Tx_data = 8'h00;
    tick(3);
    checks++; if (Sda_oen !== 1'b1)  begin errors++; $display("FAIL rst_sda_oen: got %b expected 1", Sda_oen); end
    checks++; if (Rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", Rx_data); end
    checks++; if (Rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", Rx_valid); end
    checks++; if (Tx_load !== 1'b0)  begin errors++; $display("FAIL rst_tx_load: got %b expected 0", Tx_load); end
    checks++; if (Tx_nack !== 1'b0)  begin errors++; $display("FAIL rst_tx_nack: got %b expected 0", Tx_nack); end
    checks++; if (Busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b expected 0", Busy); end
    checks++; if (Rw !== 1'b0)       begin errors++; $display("FAIL rst_rw: got %b expected 0", Rw); end
    checks++; if (Stop_det !== 1'b0) begin errors++; $display("FAIL rst_stop_det: got %b expected 0", Stop_det); end
    Rst_n = 1'b1;
    tick(20);
  endtask

  task automatic test_write;
    logic a1, a2;
    int rx0, st0;
    rx0 = n_rxv; st0 = n_stop;
    i2c_start;
    write_byte(8'h54, a1);
    write_byte(8'hA5, a2);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL wr_addr_ack: got %b expected 1", a1); end
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL wr_data_ack: got %b expected 1", a2); end
    checks++; if (Rx_data !== 8'hA5) begin errors++; $display("FAIL wr_rx_data: got %h expected a5", Rx_data); end
    checks++; if (n_rxv - rx0 !== 1) begin errors++; $display("FAIL wr_rx_valid_cnt: got %0d expected 1", n_rxv - rx0); end
    checks++; if (Rw !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL wr_rw_busy: got rw=%b busy=%b expected rw=0 busy=1", Rw, Busy); end
    i2c_stop;
    checks++; if (n_stop - st0 !== 1) begin errors++; $display("FAIL wr_stop_det: got %0d expected 1", n_stop - st0); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b expected 0", Busy); end
  endtask

  task automatic test_read;
    logic a;
    logic [7:0] b1, b2;
    int ld0, nk0;
    ld0 = n_ld; nk0 = n_nack;
    Tx_data = 8'h3C;
    i2c_start;
    write_byte(8'h55, a);
    Tx_data = 8'hC3;
    read_byte(b1, 1'b1);
    read_byte(b2, 1'b0);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got %b expected 1", a); end
    checks++; if (b1 !== 8'h3C) begin errors++; $display("FAIL rd_byte1: got %h expected 3c", b1); end
    checks++; if (b2 !== 8'hC3) begin errors++; $display("FAIL rd_byte2: got %h expected c3", b2); end
    checks++; if (n_ld - ld0 !== 2) begin errors++; $display("FAIL rd_tx_load_cnt: got %0d expected 2", n_ld - ld0); end
    checks++; if (n_nack - nk0 !== 1) begin errors++; $display("FAIL rd_tx_nack_cnt: got %0d expected 1", n_nack - nk0); end
    checks++; if (Sda_oen !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL rd_wait: got oen=%b busy=%b expected oen=1 busy=1", Sda_oen, Busy); end
    i2c_stop;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end: got %b expected 0", Busy); end
  endtask

  task automatic test_mismatch;
    logic a1, a2;
    int rx0;
    rx0 = n_rxv;
    i2c_start;
    write_byte(8'h20, a1);
    write_byte(8'hFF, a2);
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL mm_addr_nack: got ack=%b expected 0", a1); end
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL mm_data_ignored: got ack=%b expected 0", a2); end
    checks++; if (n_rxv - rx0 !== 0) begin errors++; $display("FAIL mm_rx_valid_cnt: got %0d expected 0", n_rxv - rx0); end
    i2c_stop;
  endtask

  task automatic test_rep_start;
    logic a;
    logic [7:0] b;
    int ld0;
    i2c_start;
    write_byte(8'h54, a);
    write_byte(8'h11, a);
    checks++; if (Rw !== 1'b0) begin errors++; $display("FAIL rs_rw_write: got %b expected 0", Rw); end
    Tx_data = 8'h5A;
    ld0 = n_ld;
    i2c_start;
    write_byte(8'h55, a);
    checks++; if (ld_snap - ld0 !== 0) begin errors++; $display("FAIL rs_load_before_fall: got %0d expected 0", ld_snap - ld0); end
    checks++; if (n_ld - ld0 !== 1) begin errors++; $display("FAIL rs_load_after_fall: got %0d expected 1", n_ld - ld0); end
    checks++; if (Rw !== 1'b1) begin errors++; $display("FAIL rs_rw_read: got %b expected 1", Rw); end
    read_byte(b, 1'b0);
    checks++; if (b !== 8'h5A) begin errors++; $display("FAIL rs_read_byte: got %h expected 5a", b); end
    i2c_stop;
  endtask

  task automatic test_glitch;
    int bz0, st0;
    bz0 = n_busy_rise; st0 = n_stop;
    sda_m = 1'b0; tick(FILT - 1);
    sda_m = 1'b1; tick(20);
    checks++; if (n_busy_rise - bz0 !== 0) begin errors++; $display("FAIL gl_short_start: got %0d expected 0", n_busy_rise - bz0); end
    checks++; if (n_stop - st0 !== 0) begin errors++; $display("FAIL gl_short_stop: got %0d expected 0", n_stop - st0); end
    sda_m = 1'b0; tick(FILT);
    sda_m = 1'b1; tick(20);
    checks++; if (n_busy_rise - bz0 !== 1) begin errors++; $display("FAIL gl_full_start: got %0d expected 1", n_busy_rise - bz0); end
    checks++; if (n_stop - st0 !== 1) begin errors++; $display("FAIL gl_full_stop: got %0d expected 1", n_stop - st0); end
  endtask

  task automatic test_ack_en;
    logic a1, a2;
    i2c_start;
    write_byte(8'h54, a1);
    Ack_en = 1'b0;
    write_byte(8'h77, a2);
    Ack_en = 1'b1;
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL ae_addr_ack: got %b expected 1", a1); end
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL ae_data_nack: got ack=%b expected 0", a2); end
    checks++; if (Rx_data !== 8'h77) begin errors++; $display("FAIL ae_rx_data: got %h expected 77", Rx_data); end
    i2c_stop;
  endtask

  task automatic test_reset_mid;
    i2c_start;
    send_bits(8'h54);
    checks++; if (Sda_oen !== 1'b0) begin errors++; $display("FAIL rm_ack_driven: got %b expected 0", Sda_oen); end
    #1 Rst_n = 1'b0;
    #1;
    checks++; if (Sda_oen !== 1'b1) begin errors++; $display("FAIL rm_sda_release: got %b expected 1", Sda_oen); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", Busy); end
    checks++; if (Rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data: got %h expected 00", Rx_data); end
    checks++; if (Rw !== 1'b0) begin errors++; $display("FAIL rm_rw: got %b expected 0", Rw); end
    tick(3);
    Rst_n = 1'b1;
    tick(10);
    i2c_stop;
  endtask

  task automatic test_gen_call;
    logic a, exp_a;
`ifdef I2C_SLAVE_GEN_CALL_EN
    exp_a = 1'b1;
`else
    exp_a = 1'b0;
`endif
    i2c_start;
    write_byte(8'h00, a);
    checks++; if (a !== exp_a) begin errors++; $display("FAIL gc_ack: got %b expected %b", a, exp_a); end
    i2c_stop;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_mismatch;
    test_rep_start;
    test_glitch;
    test_ack_en;
    test_reset_mid;
    test_gen_call;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte_ctrl.md
# i2c_slave_byte_ctrl

Byte-level I2C target (slave) controller: the responder end of the bus driven by the team's I2C master byte controller. It filters SCL/SDA, detects START/STOP, and receives and matches a 7-bit address. It then receives or transmits bytes with ACK/NACK handling and hands them to the host register block over single-cycle strobes. It sits between the open-drain pad cells and the target-side register file.

## Interface
- FILT, 3, glitch-filter depth in Clk cycles (1..7); a filtered line changes only after FILT consecutive equal synchronized samples.
- Clk  in  1  system clock; must be ≥ 8× SCL frequency with the default FILT.
- Rst_n  in  1  reset, asynchronous, active-low.
- Scl_i  in  1  raw SCL from pad.
- Sda_i  in  1  raw SDA from pad.
- Sda_oen  out  1  SDA output enable, active-low (0 = pull SDA low, 1 = release).
- My_addr  in  7  own address; must be static while Busy=1.
- Ack_en  in  1  1 = ACK received data bytes, 0 = NACK them; sampled on the 8th SCL fall of each data byte.
- Rx_data  out  8  last received data byte; held until the next one completes.
- Rx_valid  out  1  one-cycle strobe: Rx_data updated.
- Tx_data  in  8  next byte to transmit; must be stable whenever a Tx_load strobe can occur.
- Tx_load  out  1  one-cycle strobe: Tx_data captured into the shift register; the host may change Tx_data afterwards.
- Tx_nack  out  1  one-cycle strobe: the master NACKed a transmitted byte.
- Busy  out  1  high from START detection to STOP detection.
- Rw  out  1  R/W bit of the last matched address (1 = master reads).
- Stop_det  out  1  one-cycle strobe on STOP.

## Operation
- Input path: 2-FF synchronizer per line, then a FILT-deep filter, then edge detect on the filtered values. All "SCL rise/fall" references below mean edges of the filtered SCL.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high. Both are recognized in every state; both release SDA (Sda_oen=1) and clear the 3-bit bit counter.
  - START goes to ADDR (repeated START included).
  - STOP goes to IDLE and pulses Stop_det.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT.
- IDLE: ignores SCL/SDA except START.
- ADDR: shift SDA in MSB-first on each SCL rise. On the 8th rise, compare bits [7:1] with My_addr.
  - Match: latch Rw; on the 8th SCL fall drive Sda_oen=0 and go to ADDR_ACK.
  - Mismatch: go to WAIT.
- ADDR_ACK: on the 9th SCL fall, release SDA.
  - Rw=0: go to RX.
  - Rw=1: load Tx_data, pulse Tx_load, drive bit 7, and go to TX.
- RX: shift 8 bits on SCL rises. On the 8th rise, update Rx_data and pulse Rx_valid. On the 8th fall, drive Sda_oen = ~Ack_en and go to RX_ACK.
- RX_ACK: on the 9th fall, release SDA and go to RX.
- TX: on each SCL fall, drive the next bit (Sda_oen=0 for a 0 bit, 1 for a 1 bit). After the 8th fall, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on the 9th rise.
  - Low (ACK): on the 9th fall, load the next byte, pulse Tx_load, and go to TX.
  - High (NACK): pulse Tx_nack, keep SDA released, and go to WAIT.
- WAIT: SDA released; leave only on START or STOP.
- The bit counter wraps 7→0 at each byte boundary; ACK phases are tracked by state, not by the counter.

## Timing
- Reset values: Sda_oen=1, Rx_data=8'h00, Rx_valid=0, Tx_load=0, Tx_nack=0, Busy=0, Rw=0, Stop_det=0. State is IDLE. Filter outputs reset to 1 (bus idle).
- Pad-to-filtered latency: 2 + FILT Clk cycles.
- Sda_oen changes in the Clk cycle after the filtered SCL-fall edge is detected.
- Strobes are registered: Rx_valid is asserted the cycle after the 8th-rise detection. Tx_load and Tx_nack are asserted in the same cycle that Sda_oen is updated.
- Reset mid-transfer releases SDA immediately (asynchronously).
- A START or STOP detected in the same cycle as an SCL edge takes priority; the SCL edge is discarded.

## Configuration
- I2C_SLAVE_GEN_CALL_EN defined: address byte 8'h00 (general call, write) also matches and is ACKed. Rw=0 and the block proceeds to RX. General call with R/W=1 (8'h01) goes to WAIT.
- Not defined: only My_addr matches; 8'h00 is NACKed (goes to WAIT).

## Test plan
- My_addr=7'h2A; master sends START, 8'h54, 8'hA5, STOP with Ack_en=1 → slave ACKs both bytes; Rx_data=8'hA5 with one Rx_valid pulse per data byte; Rw=0; Stop_det pulses; Busy returns to 0.
- My_addr=7'h2A; master sends START, 8'h55, reads two bytes (ACK, then NACK) with Tx_data=8'h3C then 8'hC3 → SDA carries 3C then C3; two Tx_load pulses; one Tx_nack; slave in WAIT until STOP.
- Address 8'h20 with My_addr=7'h2A → SDA released on the 9th clock (NACK); no Rx_valid; subsequent data bytes are ignored.
- Write 8'h54, one data byte, then repeated START and 8'h55 read → Rw changes 0→1; Tx_load pulses on the 9th fall after the second address.
- Glitch test: SDA pulse of FILT-1 cycles while SCL is high → no START/STOP detected. Ack_en=0 on a data byte → NACK observed on the 9th clock.
- Assert Rst_n low while the slave drives ACK → Sda_oen=1 immediately; all outputs at their reset values. With I2C_SLAVE_GEN_CALL_EN defined, address 8'h00 is ACKed; without it, 8'h00 is NACKed.
